// File: rtl/product_catalog_selector.sv
// Product selection session controller with a programmable price table
// and per-product saturating stock counters.
module product_catalog_selector #(
    parameter int NUM_PRODUCTS = 3,
    parameter int SEL_W = 2,
    parameter int PRICE_W = 8,
    parameter int STOCK_W = 4,
    parameter int INIT_STOCK = 5,
    parameter logic [NUM_PRODUCTS*PRICE_W-1:0] PRICE_INIT = 24'h19140F
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               selector_en,
    input  logic               sel_valid,
    input  logic [SEL_W-1:0]   sel_id,
    input  logic               timeout_flag,
    input  logic               cancel,
    input  logic               vend_ack,
    input  logic               cfg_we,
    input  logic [SEL_W-1:0]   cfg_id,
    input  logic [PRICE_W-1:0] cfg_price,
    input  logic               restock_we,
    input  logic [SEL_W-1:0]   restock_id,
    input  logic [STOCK_W-1:0] restock_qty,
    output logic [PRICE_W-1:0] product_price,
    output logic [SEL_W-1:0]   product_out,
    output logic               selector_done,
    output logic               busy,
    output logic               sold_out,
    output logic               invalid_sel,
    output logic               vend_done,
    output logic [STOCK_W-1:0] stock_level
);

    localparam logic [SEL_W-1:0] MAX_ID = SEL_W'(NUM_PRODUCTS);
    localparam logic [STOCK_W-1:0] STOCK_MAX = '1;
    localparam logic [STOCK_W-1:0] STOCK_RST = STOCK_W'(INIT_STOCK);

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        HOLD
    } state_t;

    state_t state_q, state_d;

    logic [NUM_PRODUCTS-1:0][PRICE_W-1:0] price_q, price_d;
    logic [NUM_PRODUCTS-1:0][STOCK_W-1:0] stock_q, stock_d;

    logic [SEL_W-1:0]   out_q, out_d;
    logic [PRICE_W-1:0] pout_q, pout_d;
    logic               sold_q, sold_d;
    logic               inv_q, inv_d;
    logic               vdone_q, vdone_d;

    logic               sel_ok;
    logic [STOCK_W-1:0] sel_stock;
    logic [PRICE_W-1:0] sel_price;
    logic               vend_fire;
    logic [STOCK_W:0]   sum;

    always_comb begin
        sel_ok    = (sel_id != '0) && (sel_id <= MAX_ID);
        sel_stock = '0;
        sel_price = '0;
        for (int i = 0; i < NUM_PRODUCTS; i++) begin
            if (sel_id == SEL_W'(i + 1)) begin
                sel_stock = stock_q[i];
                sel_price = price_q[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        pout_d    = pout_q;
        sold_d    = 1'b0;
        inv_d     = 1'b0;
        vdone_d   = 1'b0;
        vend_fire = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (selector_en) state_d = SELECT;
            end
            SELECT: begin
                if (timeout_flag || cancel) begin
                    state_d = IDLE;
                end else if (sel_valid) begin
                    if (!sel_ok) begin
                        inv_d = 1'b1;
                    end else if (sel_stock == '0) begin
                        sold_d = 1'b1;
                    end else begin
                        state_d = HOLD;
                        out_d   = sel_id;
                        pout_d  = sel_price;
                    end
                end
            end
            HOLD: begin
                if (vend_ack || timeout_flag || cancel) begin
                    state_d = IDLE;
                    out_d   = '0;
                    pout_d  = '0;
                end
                if (vend_ack) begin
                    vend_fire = 1'b1;
                    vdone_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                out_d   = '0;
                pout_d  = '0;
            end
        endcase
    end

    // Restock and vend may hit the same counter; add first, then saturate.
    always_comb begin
        price_d = price_q;
        stock_d = stock_q;
        sum     = '0;
        for (int i = 0; i < NUM_PRODUCTS; i++) begin
            if (cfg_we && cfg_id == SEL_W'(i + 1)) price_d[i] = cfg_price;
            sum = {1'b0, stock_q[i]};
            if (restock_we && restock_id == SEL_W'(i + 1))
                sum = sum + {1'b0, restock_qty};
            if (vend_fire && out_q == SEL_W'(i + 1))
                sum = sum - (STOCK_W + 1)'(1);
            stock_d[i] = (sum > {1'b0, STOCK_MAX}) ? STOCK_MAX
                                                   : sum[STOCK_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            price_q <= PRICE_INIT;
            stock_q <= {NUM_PRODUCTS{STOCK_RST}};
            out_q   <= '0;
            pout_q  <= '0;
            sold_q  <= 1'b0;
            inv_q   <= 1'b0;
            vdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            price_q <= price_d;
            stock_q <= stock_d;
            out_q   <= out_d;
            pout_q  <= pout_d;
            sold_q  <= sold_d;
            inv_q   <= inv_d;
            vdone_q <= vdone_d;
        end
    end

    assign product_price = pout_q;
    assign product_out   = out_q;
    assign selector_done = (state_q == HOLD);
    assign busy          = (state_q != IDLE);
    assign sold_out      = sold_q;
    assign invalid_sel   = inv_q;
    assign vend_done     = vdone_q;
    assign stock_level   = sel_stock;

endmodule

// File: tb/tb_product_catalog_selector.sv
// Bench for product_catalog_selector: directed sessions checked against
// a behavioural catalogue model plus hand-computed expectations.
module tb_product_catalog_selector;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       selector_en, sel_valid, timeout_flag, cancel, vend_ack;
    logic [1:0] sel_id, cfg_id, restock_id;
    logic       cfg_we, restock_we;
    logic [7:0] cfg_price;
    logic [3:0] restock_qty;
    logic [7:0] product_price;
    logic [1:0] product_out;
    logic       selector_done, busy, sold_out, invalid_sel, vend_done;
    logic [3:0] stock_level;

    logic       b_en, b_valid;
    logic [2:0] b_sel, b_out;
    logic [7:0] b_price;
    logic       b_done, b_busy, b_sold, b_inv, b_vd;
    logic [3:0] b_stock;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    product_catalog_selector dut (
        .clk(clk), .rst_n(rst_n),
        .selector_en(selector_en), .sel_valid(sel_valid),
        .sel_id(sel_id), .timeout_flag(timeout_flag),
        .cancel(cancel), .vend_ack(vend_ack),
        .cfg_we(cfg_we), .cfg_id(cfg_id), .cfg_price(cfg_price),
        .restock_we(restock_we), .restock_id(restock_id),
        .restock_qty(restock_qty),
        .product_price(product_price), .product_out(product_out),
        .selector_done(selector_done), .busy(busy),
        .sold_out(sold_out), .invalid_sel(invalid_sel),
        .vend_done(vend_done), .stock_level(stock_level)
    );

    product_catalog_selector #(.SEL_W(3)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .selector_en(b_en), .sel_valid(b_valid), .sel_id(b_sel),
        .timeout_flag(1'b0), .cancel(1'b0), .vend_ack(1'b0),
        .cfg_we(1'b0), .cfg_id(3'd0), .cfg_price(8'd0),
        .restock_we(1'b0), .restock_id(3'd0), .restock_qty(4'd0),
        .product_price(b_price), .product_out(b_out),
        .selector_done(b_done), .busy(b_busy),
        .sold_out(b_sold), .invalid_sel(b_inv),
        .vend_done(b_vd), .stock_level(b_stock)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Catalogue model: session flag, held item and tables as plain ints.
    bit m_busy, m_sold, m_inv, m_vd;
    int m_held, m_price;
    int m_stock[1:3];
    int m_tab[1:3];

    always @(posedge clk or negedge rst_n) begin : model
        int vend_id;
        int s;
        if (!rst_n) begin
            m_busy = 0; m_sold = 0; m_inv = 0; m_vd = 0;
            m_held = 0; m_price = 0;
            m_tab[1] = 15; m_tab[2] = 20; m_tab[3] = 25;
            for (int k = 1; k <= 3; k++) m_stock[k] = 5;
        end else begin
            vend_id = 0;
            m_sold = 0; m_inv = 0; m_vd = 0;
            if (!m_busy) begin
                m_busy = selector_en;
            end else if (m_held == 0) begin
                if (timeout_flag || cancel) m_busy = 0;
                else if (sel_valid) begin
                    if (sel_id < 1 || sel_id > 3) m_inv = 1;
                    else if (m_stock[sel_id] == 0) m_sold = 1;
                    else begin
                        m_held = int'(sel_id);
                        m_price = m_tab[sel_id];
                    end
                end
            end else if (vend_ack || timeout_flag || cancel) begin
                if (vend_ack) begin
                    vend_id = m_held;
                    m_vd = 1;
                end
                m_busy = 0; m_held = 0; m_price = 0;
            end
            for (int k = 1; k <= 3; k++) begin
                s = m_stock[k];
                if (restock_we && restock_id == k) s += int'(restock_qty);
                if (vend_id == k) s -= 1;
                m_stock[k] = (s > 15) ? 15 : s;
            end
            if (cfg_we && cfg_id >= 1) m_tab[cfg_id] = int'(cfg_price);
        end
    end

    always @(negedge clk) begin : compare
        int exp_lvl;
        exp_lvl = (sel_id >= 1 && sel_id <= 3) ? m_stock[sel_id] : 0;
        chk("busy", int'(busy), int'(m_busy));
        chk("selector_done", int'(selector_done), int'(m_held != 0));
        chk("product_out", int'(product_out), m_held);
        chk("product_price", int'(product_price), m_price);
        chk("sold_out", int'(sold_out), int'(m_sold));
        chk("invalid_sel", int'(invalid_sel), int'(m_inv));
        chk("vend_done", int'(vend_done), int'(m_vd));
        chk("stock_level", int'(stock_level), exp_lvl);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start();
        selector_en = 1; tick(); selector_en = 0;
    endtask

    task automatic pick(input int id);
        sel_valid = 1; sel_id = 2'(id); tick(); sel_valid = 0;
    endtask

    task automatic vend_once(input int id);
        start(); pick(id); vend_ack = 1; tick(); vend_ack = 0;
    endtask

    task automatic restock(input int id, input int q);
        restock_we = 1; restock_id = 2'(id); restock_qty = 4'(q);
        tick(); restock_we = 0;
    endtask

    task automatic lvl(input string name, input int id, input int exp);
        sel_id = 2'(id); #1;
        chk(name, int'(stock_level), exp);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        selector_en = 0; sel_valid = 0; sel_id = 0;
        timeout_flag = 0; cancel = 0; vend_ack = 0;
        cfg_we = 0; cfg_id = 0; cfg_price = 0;
        restock_we = 0; restock_id = 0; restock_qty = 0;
        b_en = 0; b_valid = 0; b_sel = 0;
        repeat (3) tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_price", int'(product_price), 0);
        rst_n = 1;
        tick();

        // wide-ID variant: 5 is out of range, 3 is accepted
        b_en = 1; tick(); b_en = 0;
        b_valid = 1; b_sel = 3'd5; tick();
        chk("w_inv5", int'(b_inv), 1);
        chk("w_busy", int'(b_busy), 1);
        b_sel = 3'd3; tick(); b_valid = 0;
        chk("w_inv_clr", int'(b_inv), 0);
        chk("w_price3", int'(b_price), 25);

        // basic vend of product 2
        start();
        chk("t1_busy", int'(busy), 1);
        pick(2);
        chk("t1_price", int'(product_price), 20);
        chk("t1_out", int'(product_out), 2);
        vend_ack = 1; tick(); vend_ack = 0;
        chk("t1_vdone", int'(vend_done), 1);
        chk("t1_busy0", int'(busy), 0);
        chk("t1_stock", int'(stock_level), 4);

        // drain product 1, then sold out
        repeat (5) vend_once(1);
        start();
        pick(1);
        chk("t2_sold", int'(sold_out), 1);
        chk("t2_done", int'(selector_done), 0);
        chk("t2_busy", int'(busy), 1);
        tick();
        pick(3);
        chk("t2_price3", int'(product_price), 25);

        // timeout in HOLD, then vend_ack with cancel
        timeout_flag = 1; tick(); timeout_flag = 0;
        chk("t4_out", int'(product_out), 0);
        chk("t4_busy", int'(busy), 0);
        lvl("t4_stock3", 3, 5);
        start(); pick(3);
        vend_ack = 1; cancel = 1; tick(); vend_ack = 0; cancel = 0;
        chk("t4_vdone", int'(vend_done), 1);
        lvl("t4_stock3b", 3, 4);

        // invalid ID 0, then ID 3 accepted
        start(); pick(0);
        chk("t3_inv", int'(invalid_sel), 1);
        pick(3);
        chk("t3_inv_clr", int'(invalid_sel), 0);
        chk("t3_out", int'(product_out), 3);
        cancel = 1; tick(); cancel = 0;

        // price write while held, write/select collision, saturation
        restock(1, 5);
        lvl("t5_rs1", 1, 5);
        start(); pick(1);
        cfg_we = 1; cfg_id = 1; cfg_price = 30; tick(); cfg_we = 0;
        chk("t5_held15", int'(product_price), 15);
        cancel = 1; tick(); cancel = 0;
        start(); pick(1);
        chk("t5_new30", int'(product_price), 30);
        cancel = 1; tick(); cancel = 0;
        start();
        cfg_we = 1; cfg_id = 3; cfg_price = 40; pick(3); cfg_we = 0;
        chk("t5_old25", int'(product_price), 25);
        cancel = 1; tick(); cancel = 0;
        start(); pick(3);
        chk("t5_new40", int'(product_price), 40);
        cancel = 1; tick(); cancel = 0;
        restock(1, 15);
        lvl("t5_sat", 1, 15);
        restock(0, 3);
        cfg_we = 1; cfg_id = 0; cfg_price = 99; tick(); cfg_we = 0;
        lvl("t5_inv_rs2", 2, 4);
        lvl("t5_inv_rs3", 3, 4);

        // restock and vend on the same product in one cycle
        start(); pick(2);
        vend_ack = 1; restock_we = 1; restock_id = 2; restock_qty = 3;
        tick();
        vend_ack = 0; restock_we = 0;
        chk("t6_vdone", int'(vend_done), 1);
        lvl("t6_stock2", 2, 6);

        // reset in HOLD restores everything
        start(); pick(2);
        chk("t6_hold", int'(selector_done), 1);
        rst_n = 0; #1;
        chk("t6_rst_out", int'(product_out), 0);
        chk("t6_rst_done", int'(selector_done), 0);
        chk("t6_rst_busy", int'(busy), 0);
        lvl("t6_rst_s1", 1, 5);
        lvl("t6_rst_s2", 2, 5);
        tick();
        rst_n = 1;
        tick();
        start(); pick(1);
        chk("t6_price15", int'(product_price), 15);
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
